// File: rtl/seq_serializer.sv
// seq_serializer
//   Parallel-to-serial front end for the serial sequence-detector chain.
//   Words arrive over a valid/ready handshake into a one-word holding
//   register, move into the active shifter, and leave one bit per enabled
//   clock on sout. When the shifter finishes a word while the holding
//   register is full, the held word is loaded immediately, so streaming
//   has no gap between words.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   clr        : synchronous flush of both the hold and the shift words
//   en         : bit-rate tick, one bit emitted per clk edge with en=1
//   in_data    : WIDTH-bit word to serialize
//   in_valid   : in_data is valid
//   in_ready   : the holding register can accept a word
//   sout       : registered serial bit (to detector din)
//   sout_valid : sout carries a data bit rather than idle fill
//   word_done  : one-clock pulse while the last bit of a word is on sout
//   busy       : a word is held or being shifted
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             hold_full_q, hold_full_d;
    logic             loaded_q, loaded_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sout_q, sout_d;
    logic             sout_valid_q, sout_valid_d;
    logic             word_done_q, word_done_d;
    logic             cur_bit;

    // cnt counts bits already sent; map it to a shifter index for the
    // configured bit order.
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] c);
        if (MSB_FIRST) begin
            bit_index = LAST - c;
        end else begin
            bit_index = c;
        end
    endfunction

    assign cur_bit = shreg_q[bit_index(cnt_q)];

    always_comb begin
        hold_d       = hold_q;
        shreg_d      = shreg_q;
        hold_full_d  = hold_full_q;
        loaded_d     = loaded_q;
        cnt_d        = cnt_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        word_done_d  = 1'b0;

        // Accept and load are mutually exclusive: accept needs an empty
        // hold, load needs a full one.
        if (in_valid && !hold_full_q) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (!loaded_q && hold_full_q) begin
            shreg_d     = hold_q;
            loaded_d    = 1'b1;
            cnt_d       = '0;
            hold_full_d = 1'b0;
        end

        if (en) begin
            if (loaded_q) begin
                sout_d       = cur_bit;
                sout_valid_d = 1'b1;
                if (cnt_q == LAST) begin
                    word_done_d = 1'b1;
                    cnt_d       = '0;
                    // Chain straight into the held word so the next tick
                    // carries its first bit with no idle gap.
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        loaded_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                sout_d       = IDLE_BIT;
                sout_valid_d = 1'b0;
            end
        end

        // Flush wins over everything; bits already sent stay sent.
        if (clr) begin
            hold_full_d  = 1'b0;
            loaded_d     = 1'b0;
            cnt_d        = '0;
            sout_d       = IDLE_BIT;
            sout_valid_d = 1'b0;
            word_done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_full_q  <= 1'b0;
            loaded_q     <= 1'b0;
            cnt_q        <= '0;
            sout_q       <= IDLE_BIT;
            sout_valid_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            hold_full_q  <= hold_full_d;
            loaded_q     <= loaded_d;
            cnt_q        <= cnt_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            word_done_q  <= word_done_d;
        end
    end

    // Word storage is qualified by hold_full/loaded, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_q  <= hold_d;
        shreg_q <= shreg_d;
    end

    assign in_ready   = ~hold_full_q;
    assign busy       = loaded_q | hold_full_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign word_done  = word_done_q;

endmodule

// File: tb/tb_seq_serializer.sv
module tb_seq_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clr, en, in_valid;
    logic [7:0] in_data;
    logic       in_ready, sout, sout_valid, word_done, busy;

    logic       en4, in4_valid;
    logic [3:0] in4_data;
    logic       in4_ready, sout4, sout4_valid, word4_done, busy4;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sout(sout), .sout_valid(sout_valid), .word_done(word_done), .busy(busy)
    );

    seq_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut4 (
        .clk(clk), .rst(rst), .clr(clr), .en(en4),
        .in_data(in4_data), .in_valid(in4_valid), .in_ready(in4_ready),
        .sout(sout4), .sout_valid(sout4_valid), .word_done(word4_done), .busy(busy4)
    );

    typedef struct { logic [7:0] data; logic [7:0] seq; } vec_t;
    typedef struct { logic b; logic last; } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    int  checks = 0;
    int  errors = 0;
    int  n_pop  = 0;
    int  wd_cnt = 0;
    bit  mon_on = 0;
    bit  en_mode = 0;
    int  ph = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // en driver: full rate, or one tick every third clock
    always @(posedge clk) begin
        #1;
        if (en_mode) begin
            ph = (ph == 2) ? 0 : ph + 1;
            en = (ph == 0);
        end else begin
            en = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every emitted bit
    always @(posedge clk) begin
        logic en_s, clr_s, rst_s, prev_sout, prev_valid;
        exp_t e;
        en_s = en; clr_s = clr; rst_s = rst;
        #1;
        if (mon_on && rst_s && rst) begin
            if (clr_s) begin
                check("clr_valid", sout_valid, 0);
                check("clr_done", word_done, 0);
            end else if (en_s) begin
                if (sout_valid) begin
                    if (sbq.size() == 0) begin
                        check("extra_bit", sout_valid, 0);
                    end else begin
                        e = sbq.pop_front();
                        check("sout_bit", sout, e.b);
                        check("word_done", word_done, e.last);
                        n_pop++;
                    end
                end else begin
                    check("idle_sout", sout, 0);
                    check("idle_done", word_done, 0);
                end
            end else begin
                check("hold_sout", sout, prev_sout);
                check("hold_valid", sout_valid, prev_valid);
                check("en0_done", word_done, 0);
            end
            if (word_done) wd_cnt++;
        end
        prev_sout  = sout;
        prev_valid = sout_valid;
    end

    task automatic push_word(input logic [7:0] seq);
        for (int i = 7; i >= 0; i--) begin
            exp_t e;
            e.b = seq[i];
            e.last = (i == 0);
            sbq.push_back(e);
        end
    endtask

    // Returns 1 ns after the accepting edge with in_valid still high
    task automatic send(input vec_t v);
        bit ok;
        ok = 0;
        in_data  = v.data;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        check("accept_timeout", ok, 1);
        @(posedge clk);
        push_word(v.seq);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 400; k++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        check(name, sbq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int run, base;
        vecs[0] = '{data: 8'hDA, seq: 8'b1101_1010};
        vecs[1] = '{data: 8'h0F, seq: 8'b0000_1111};
        vecs[2] = '{data: 8'hA5, seq: 8'b1010_0101};
        vecs[3] = '{data: 8'h0D, seq: 8'b0000_1101};
        vecs[4] = '{data: 8'hFF, seq: 8'b1111_1111};
        vecs[5] = '{data: 8'h3C, seq: 8'b0011_1100};

        rst = 1'b1; clr = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = '0;
        en4 = 1'b1; in4_valid = 1'b0; in4_data = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_sout", sout, 0);
        check("rst_valid", sout_valid, 0);
        check("rst_done", word_done, 0);
        check("rst4_sout", sout4, 1);
        check("rst4_ready", in4_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mon_on = 1;
        @(posedge clk); #1;

        // Single word with first-bit latency
        send(vecs[0]);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("latency_load", sout_valid, 0);
        @(posedge clk); #1;
        check("latency_first", sout_valid, 1);
        drain("drain_single");
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 1);

        // Back-to-back with in_valid held
        send(vecs[0]);
        check("ready_low_full", in_ready, 0);
        send(vecs[1]);
        in_valid = 1'b0;
        run = 0;
        for (int k = 0; k < 40; k++) begin
            if (sout_valid) run++;
            else if (run > 0) break;
            @(posedge clk); #1;
        end
        check("stream_run", run, 16);
        drain("drain_b2b");

        // Slow bit rate
        @(negedge clk);
        wd_cnt = 0;
        en_mode = 1;
        send(vecs[2]);
        in_valid = 1'b0;
        drain("drain_slow");
        repeat (4) @(negedge clk);
        check("slow_wd_width", wd_cnt, 1);
        en_mode = 0;
        repeat (3) @(posedge clk);
        #1;

        // Table stream
        for (int i = 0; i < 6; i++) send(vecs[i]);
        in_valid = 1'b0;
        drain("drain_table");
        repeat (2) @(negedge clk);
        check("table_busy", busy, 0);

        // 4-bit LSB-first instance, IDLE_BIT = 1
        @(posedge clk); #1;
        in4_data = 4'b0011; in4_valid = 1'b1;
        @(posedge clk); #1;
        in4_valid = 1'b0;
        @(posedge clk); #1;
        check("w4_load_valid", sout4_valid, 0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp4;
            exp4 = 4'b0011;
            @(posedge clk); #1;
            check("w4_bit", sout4, exp4[i]);
            check("w4_valid", sout4_valid, 1);
            check("w4_done", word4_done, (i == 3));
        end
        @(posedge clk); #1;
        check("w4_idle_sout", sout4, 1);
        check("w4_idle_valid", sout4_valid, 0);
        check("w4_idle_busy", busy4, 0);

        // Flush after bit 3 with hold full
        base = n_pop;
        send(vecs[4]);
        send(vecs[5]);
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (n_pop - base >= 3) break;
            @(negedge clk);
        end
        check("clr_hold_full", in_ready, 0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        sbq.delete();
        check("clr_sout_valid", sout_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        check("clr_still_idle", busy, 0);

        // Asynchronous reset mid-word
        base = n_pop;
        send(vecs[5]);
        in_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (n_pop - base >= 2) break;
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        sbq.delete();
        check("arst_valid", sout_valid, 0);
        check("arst_sout", sout, 0);
        check("arst_done", word_done, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(vecs[3]);
        in_valid = 1'b0;
        drain("drain_after_rst");
        repeat (4) @(negedge clk);
        check("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
